// File: rtl/controle_rega_multizona.sv
// Multi-zone irrigation scheduler: scans the zones in order and waters one at a time, with a timed pause between zones and a tank-level interlock.
// Latency: outputs are registered; the valve opens 1 cycle after the SCAN cycle and closes in the cycle after the terminal tick.
// Backpressure: none. Optional build macro ZONA_MASCARA_EN adds the zona_habilitada per-zone enable input.
module controle_rega_multizona #(
    parameter int N_ZONES = 4,
    parameter int T_W     = 6,
    parameter int DUR_GOT = 20,
    parameter int DUR_ASP = 10,
    parameter int PAUSA_S = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_1s,
    input  logic               iniciar,
    input  logic [N_ZONES-1:0] umidadeAr,
    input  logic [N_ZONES-1:0] umidadeSolo,
    input  logic [N_ZONES-1:0] temperatura,
    input  logic [2:0]         nivelDagua,
`ifdef ZONA_MASCARA_EN
    input  logic [N_ZONES-1:0] zona_habilitada,
`endif
    output logic [N_ZONES-1:0] valvulas,
    output logic               aspersao,
    output logic               gotejamento,
    output logic [3:0]         zona_ativa,
    output logic [T_W-1:0]     tempo_restante,
    output logic               ocupado,
    output logic               alarme,
    output logic               erro
);

    localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        REGA  = 2'd2,
        PAUSA = 2'd3
    } estado_t;

    estado_t            estado;

    logic [ZW-1:0]      zona_idx;
    logic               zona_hab;
    logic               nivel_vazio;
    logic               nivel_baixo;
    logic               nivel_invalido;
    logic               modo_got;
    logic               modo_asp;
    logic               ultima_zona;
    logic [N_ZONES-1:0] onehot_zona;
    logic               intertravamento;
    logic               parar;
    logic               fim_zona;
    logic               pula_zona;
    logic               avancar;

    assign zona_idx = zona_ativa[ZW-1:0];

`ifdef ZONA_MASCARA_EN
    assign zona_hab = zona_habilitada[zona_idx];
`else
    assign zona_hab = 1'b1;
`endif

    // Decode tank level, pick the mode for the current zone, and derive the transition events
    always_comb begin
        nivel_vazio    = (nivelDagua == 3'b000);
        nivel_baixo    = (nivelDagua == 3'b001);
        nivel_invalido = !((nivelDagua == 3'b000) || (nivelDagua == 3'b001) ||
                           (nivelDagua == 3'b011) || (nivelDagua == 3'b111));

        modo_got = 1'b0;
        modo_asp = 1'b0;
        if (!nivel_vazio && !nivel_invalido && zona_hab && !umidadeSolo[zona_idx]) begin
            // A low tank cannot feed sprinklers, so it falls back to drip
            if (temperatura[zona_idx] || !umidadeAr[zona_idx] || nivel_baixo) begin
                modo_got = 1'b1;
            end else begin
                modo_asp = 1'b1;
            end
        end

        ultima_zona = (zona_ativa == 4'(N_ZONES - 1));
        onehot_zona = {{(N_ZONES-1){1'b0}}, 1'b1} << zona_idx;

        // Interlock outranks a stop request, which outranks any tick
        intertravamento = (estado != IDLE) && (nivel_vazio || nivel_invalido);
        parar           = (estado != IDLE) && iniciar;

        // A zone finishes when its enable drops, or on the terminal tick of the
        // pause (or of the watering itself when there is no pause)
        fim_zona = 1'b0;
        if ((estado == REGA) || (estado == PAUSA)) begin
            if (!zona_hab) begin
                fim_zona = 1'b1;
            end else if (tick_1s && (tempo_restante == T_W'(1)) &&
                         ((estado == PAUSA) || (PAUSA_S == 0))) begin
                fim_zona = 1'b1;
            end
        end

        pula_zona = (estado == SCAN) && !modo_got && !modo_asp;
        avancar   = fim_zona || pula_zona;
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado         <= IDLE;
            valvulas       <= '0;
            aspersao       <= 1'b0;
            gotejamento    <= 1'b0;
            zona_ativa     <= '0;
            tempo_restante <= '0;
            ocupado        <= 1'b0;
            alarme         <= 1'b0;
            erro           <= 1'b0;
        end else if (intertravamento || parar || (avancar && ultima_zona)) begin
            // Abort, stop, or end of the last zone: everything off, back to IDLE
            if (intertravamento && nivel_vazio) begin
                alarme <= 1'b1;
            end
            if (intertravamento && nivel_invalido) begin
                erro <= 1'b1;
            end
            estado         <= IDLE;
            valvulas       <= '0;
            aspersao       <= 1'b0;
            gotejamento    <= 1'b0;
            zona_ativa     <= '0;
            tempo_restante <= '0;
            ocupado        <= 1'b0;
        end else if (avancar) begin
            // Move on to scan the next zone
            estado         <= SCAN;
            valvulas       <= '0;
            aspersao       <= 1'b0;
            gotejamento    <= 1'b0;
            zona_ativa     <= zona_ativa + 4'd1;
            tempo_restante <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        // Latched flags clear only once the tank reads sane again
                        if (!nivel_vazio && !nivel_invalido) begin
                            alarme <= 1'b0;
                            erro   <= 1'b0;
                        end
                        estado         <= SCAN;
                        zona_ativa     <= '0;
                        tempo_restante <= '0;
                        ocupado        <= 1'b1;
                    end
                end
                SCAN: begin
                    // Only reached with a watering mode selected; skips went through avancar
                    estado         <= REGA;
                    valvulas       <= onehot_zona;
                    aspersao       <= modo_asp;
                    gotejamento    <= modo_got;
                    tempo_restante <= modo_asp ? T_W'(DUR_ASP) : T_W'(DUR_GOT);
                end
                REGA: begin
                    if (tick_1s) begin
                        if (tempo_restante == T_W'(1)) begin
                            // Terminal tick with a non-zero pause configured
                            estado         <= PAUSA;
                            valvulas       <= '0;
                            aspersao       <= 1'b0;
                            gotejamento    <= 1'b0;
                            tempo_restante <= T_W'(PAUSA_S);
                        end else begin
                            tempo_restante <= tempo_restante - T_W'(1);
                        end
                    end
                end
                PAUSA: begin
                    if (tick_1s) begin
                        tempo_restante <= tempo_restante - T_W'(1);
                    end
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_rega_multizona.sv
// Directed bench for the multi-zone irrigation scheduler.
// Drives inputs and samples outputs on the falling edge; the DUT acts on the rising edge.
// Expected values are hand-derived from the behavioural description.
module tb_controle_rega_multizona;

    logic       clock;
    logic       reset;
    logic       tick_1s;
    logic       iniciar;
    logic [3:0] umidadeAr;
    logic [3:0] umidadeSolo;
    logic [3:0] temperatura;
    logic [2:0] nivelDagua;
    logic [3:0] zona_habilitada;
    logic [3:0] valvulas;
    logic       aspersao;
    logic       gotejamento;
    logic [3:0] zona_ativa;
    logic [5:0] tempo_restante;
    logic       ocupado;
    logic       alarme;
    logic       erro;

    int errors = 0;
    int checks = 0;

    controle_rega_multizona #(
        .N_ZONES(4), .T_W(6), .DUR_GOT(20), .DUR_ASP(10), .PAUSA_S(2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .tick_1s        (tick_1s),
        .iniciar        (iniciar),
        .umidadeAr      (umidadeAr),
        .umidadeSolo    (umidadeSolo),
        .temperatura    (temperatura),
        .nivelDagua     (nivelDagua),
`ifdef ZONA_MASCARA_EN
        .zona_habilitada(zona_habilitada),
`endif
        .valvulas       (valvulas),
        .aspersao       (aspersao),
        .gotejamento    (gotejamento),
        .zona_ativa     (zona_ativa),
        .tempo_restante (tempo_restante),
        .ocupado        (ocupado),
        .alarme         (alarme),
        .erro           (erro)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1s = 1'b1;
            @(negedge clock);
            tick_1s = 1'b0;
        end
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        tick_1s         = 1'b0;
        iniciar         = 1'b0;
        umidadeAr       = 4'b0000;
        umidadeSolo     = 4'b1111;
        temperatura     = 4'b0000;
        nivelDagua      = 3'b111;
        zona_habilitada = 4'b1111;
        cyc(3);

        // Reset state
        chk("rst_valvulas", valvulas, 4'b0000);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_alarme", alarme, 1'b0);
        chk("rst_erro", erro, 1'b0);
        chk("rst_tempo", tempo_restante, 6'd0);
        chk("rst_zona", zona_ativa, 4'd0);
        chk("rst_modo", {aspersao, gotejamento}, 2'b00);
        reset = 1'b0;
        cyc(1);

        // T1: zone0 sprinkler, zones 1-3 humid
        umidadeSolo = 4'b1110;
        umidadeAr   = 4'b0001;
        temperatura = 4'b0000;
        nivelDagua  = 3'b111;
        pulso_iniciar();
        chk("t1_scan_ocupado", ocupado, 1'b1);
        chk("t1_scan_valvulas", valvulas, 4'b0000);
        cyc(1);
        chk("t1_rega_valvulas", valvulas, 4'b0001);
        chk("t1_rega_modo", {aspersao, gotejamento}, 2'b10);
        chk("t1_rega_tempo", tempo_restante, 6'd10);
        ticks(9);
        chk("t1_tempo_1", tempo_restante, 6'd1);
        chk("t1_still_open", valvulas, 4'b0001);
        ticks(1);
        chk("t1_pausa_valvulas", valvulas, 4'b0000);
        chk("t1_pausa_tempo", tempo_restante, 6'd2);
        chk("t1_pausa_asp", aspersao, 1'b0);
        ticks(2);
        chk("t1_scan_z1", zona_ativa, 4'd1);
        chk("t1_scan_z1_ocupado", ocupado, 1'b1);
        cyc(3);
        chk("t1_idle_ocupado", ocupado, 1'b0);
        chk("t1_idle_zona", zona_ativa, 4'd0);

        // T2: low level demotes zone2 to drip
        nivelDagua  = 3'b001;
        umidadeSolo = 4'b1011;
        umidadeAr   = 4'b0100;
        temperatura = 4'b0000;
        pulso_iniciar();
        cyc(3);
        chk("t2_valvulas", valvulas, 4'b0100);
        chk("t2_modo", {aspersao, gotejamento}, 2'b01);
        chk("t2_tempo", tempo_restante, 6'd20);
        chk("t2_zona", zona_ativa, 4'd2);
        ticks(19);
        chk("t2_tempo_1", tempo_restante, 6'd1);
        chk("t2_still_open", valvulas, 4'b0100);
        ticks(1);
        chk("t2_closed", valvulas, 4'b0000);
        ticks(2);
        cyc(1);
        chk("t2_idle", ocupado, 1'b0);

        // T3: tank empties during zone1 drip
        nivelDagua  = 3'b111;
        umidadeSolo = 4'b1101;
        umidadeAr   = 4'b0000;
        pulso_iniciar();
        cyc(2);
        chk("t3_valvulas", valvulas, 4'b0010);
        chk("t3_modo", {aspersao, gotejamento}, 2'b01);
        ticks(3);
        chk("t3_tempo", tempo_restante, 6'd17);
        nivelDagua = 3'b000;
        cyc(1);
        chk("t3_abort_valvulas", valvulas, 4'b0000);
        chk("t3_alarme", alarme, 1'b1);
        chk("t3_abort_ocupado", ocupado, 1'b0);
        chk("t3_erro", erro, 1'b0);
        pulso_iniciar();
        chk("t3_restart_alarme", alarme, 1'b1);
        chk("t3_restart_ocupado", ocupado, 1'b1);
        cyc(1);
        chk("t3_reabort_ocupado", ocupado, 1'b0);
        chk("t3_reabort_alarme", alarme, 1'b1);

        // T4: invalid level code during zone1 drip
        nivelDagua = 3'b111;
        pulso_iniciar();
        chk("t4_alarme_clear", alarme, 1'b0);
        cyc(2);
        chk("t4_valvulas", valvulas, 4'b0010);
        nivelDagua = 3'b101;
        cyc(1);
        chk("t4_erro", erro, 1'b1);
        chk("t4_abort_valvulas", valvulas, 4'b0000);
        chk("t4_abort_ocupado", ocupado, 1'b0);
        nivelDagua = 3'b111;
        pulso_iniciar();
        chk("t4_erro_clear", erro, 1'b0);
        chk("t4_restart_zona", zona_ativa, 4'd0);
        chk("t4_restart_ocupado", ocupado, 1'b1);

        // T5: stop beats tick with five seconds left; level drop to low keeps drip
        cyc(2);
        chk("t5_valvulas", valvulas, 4'b0010);
        nivelDagua = 3'b001;
        ticks(15);
        chk("t5_tempo_5", tempo_restante, 6'd5);
        chk("t5_modo_kept", {aspersao, gotejamento}, 2'b01);
        iniciar = 1'b1;
        tick_1s = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        tick_1s = 1'b0;
        chk("t5_stop_ocupado", ocupado, 1'b0);
        chk("t5_stop_tempo", tempo_restante, 6'd0);
        chk("t5_stop_valvulas", valvulas, 4'b0000);
        chk("t5_stop_zona", zona_ativa, 4'd0);
        ticks(2);
        chk("t5_idle_tick_ignored", {ocupado, tempo_restante}, 7'd0);

`ifdef ZONA_MASCARA_EN
        // T6: zone2 masked, all zones dry -> sprinkler on 0,1,3
        nivelDagua      = 3'b111;
        umidadeSolo     = 4'b0000;
        umidadeAr       = 4'b1111;
        temperatura     = 4'b0000;
        zona_habilitada = 4'b1011;
        pulso_iniciar();
        cyc(1);
        chk("t6_z0", valvulas, 4'b0001);
        ticks(12);
        cyc(1);
        chk("t6_z1", valvulas, 4'b0010);
        ticks(12);
        cyc(2);
        chk("t6_z3", valvulas, 4'b1000);
        chk("t6_z3_zona", zona_ativa, 4'd3);
        zona_habilitada = 4'b0011;
        cyc(1);
        chk("t6_mask_end", {ocupado, valvulas}, 5'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
